// File: rtl/rv32_lsu_pkg.sv
// Shared definitions for the RV32 load/store unit: funct3 encodings, FSM
// state type and the data-memory word-address type.
package rv32_lsu_pkg;

  localparam int LSU_DMEM_AW = 12;

  typedef logic [LSU_DMEM_AW-1:0] rv_dmem_addr_t;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LD_DATA   = 2'd1,
    RMW_MERGE = 2'd2,
    ST_WRITE  = 2'd3
  } lsu_state_t;

  // Halfword accesses (signed or unsigned) share the same alignment rule.
  function automatic logic f3_is_half(input logic [2:0] f3);
    return (f3 == LSU_F3_H) || (f3 == LSU_F3_HU);
  endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Byte-lane datapath for the LSU: extracts/extends load data from a BRAM
// word and merges sub-word store data into a word for read-modify-write.
module rv32_lsu_align
  import rv32_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane, extend it for loads, and splice store data in.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    byte_sel  = rdata[7:0];
    half_sel  = lane[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    merged    = rdata;

    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase

    case (funct3)
      LSU_F3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LSU_F3_BU: load_data = {24'd0, byte_sel};
      LSU_F3_H:  load_data = {{16{half_sel[15]}}, half_sel};
      LSU_F3_HU: load_data = {16'd0, half_sel};
      default:   load_data = rdata;
    endcase

    if (funct3 == LSU_F3_H) begin
      if (lane[1]) merged[31:16] = wdata[15:0];
      else         merged[15:0]  = wdata[15:0];
    end else begin
      case (lane)
        2'd0:    merged[7:0]   = wdata[7:0];
        2'd1:    merged[15:8]  = wdata[7:0];
        2'd2:    merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end
  end

endmodule

// File: rtl/rv32_lsu.sv
// RV32 load/store unit in front of a 1-cycle-read BRAM without byte enables.
// One request at a time; sub-word stores are done as read-modify-write.
module rv32_lsu
  import rv32_lsu_pkg::*;
#(
  parameter int         DMEM_AW       = LSU_DMEM_AW,
  parameter logic [4:0] RESET_RESP_RD = 5'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_mode,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_store,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [4:0]         req_rd,
  output logic               resp_valid,
  output logic               resp_we,
  output logic [4:0]         resp_rd,
  output logic [31:0]        resp_data,
  output logic               resp_misaligned,
  output logic               resp_illegal,
  output logic [DMEM_AW-1:0] mem_raddr,
  input  logic [31:0]        mem_rdata,
  output logic [DMEM_AW-1:0] mem_waddr,
  output logic [31:0]        mem_wdata,
  output logic               mem_wen
);

  lsu_state_t         state;
  logic [DMEM_AW-1:0] lat_addr;
  logic [1:0]         lat_lane;
  logic [2:0]         lat_f3;
  logic [31:0]        lat_data;
  logic [4:0]         lat_rd;

  logic               accept;
  logic               misaligned;
  logic               illegal;
  logic [31:0]        load_data;
  logic [31:0]        merged;
  logic               unused_addr_bits;

  // Addresses wrap inside the BRAM; the high byte-address bits are dropped.
  assign unused_addr_bits = ^req_addr[31:DMEM_AW+2];

  assign req_ready = (state == IDLE) && !prog_mode;
  assign accept    = req_valid && req_ready;

  assign misaligned = (f3_is_half(req_funct3) && req_addr[0]) ||
                      ((req_funct3 == LSU_F3_W) && (req_addr[1:0] != 2'b00));
  assign illegal    = req_store
                      ? (req_funct3 > LSU_F3_W)
                      : ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                         (req_funct3 == 3'b111));

  // The read port follows the live request in IDLE so load data is ready next cycle.
  assign mem_raddr = (state == IDLE) ? req_addr[DMEM_AW+1:2] : lat_addr;
  assign mem_waddr = lat_addr;
  assign mem_wdata = lat_data;
  // NOTE: the write enable is gated by rst_n combinationally so a reset cycle
  // can never commit a write, even while the state register still says ST_WRITE.
  assign mem_wen   = (state == ST_WRITE) && rst_n;

  rv32_lsu_align u_align (
    .funct3    (lat_f3),
    .lane      (lat_lane),
    .rdata     (mem_rdata),
    .wdata     (lat_data),
    .load_data (load_data),
    .merged    (merged)
  );

  // Request FSM with latched operands and registered response outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state           <= IDLE;
      lat_addr        <= '0;
      lat_lane        <= '0;
      lat_f3          <= '0;
      lat_data        <= '0;
      lat_rd          <= '0;
      resp_valid      <= 1'b0;
      resp_we         <= 1'b0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      resp_data       <= '0;
      resp_rd         <= RESET_RESP_RD;
    end else begin
      resp_valid      <= 1'b0;
      resp_we         <= 1'b0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            lat_addr <= req_addr[DMEM_AW+1:2];
            lat_lane <= req_addr[1:0];
            lat_f3   <= req_funct3;
            lat_data <= req_wdata;
            lat_rd   <= req_rd;
            if (misaligned || illegal) begin
              resp_valid      <= 1'b1;
              resp_misaligned <= misaligned;
              resp_illegal    <= illegal;
              resp_data       <= '0;
              resp_rd         <= req_rd;
            end else if (!req_store) begin
              state <= LD_DATA;
            end else if (req_funct3 == LSU_F3_W) begin
              state      <= ST_WRITE;
              resp_valid <= 1'b1;
              resp_data  <= '0;
              resp_rd    <= req_rd;
            end else begin
              state <= RMW_MERGE;
            end
          end
        end
        LD_DATA: begin
          resp_valid <= 1'b1;
          resp_we    <= 1'b1;
          resp_data  <= load_data;
          resp_rd    <= lat_rd;
          state      <= IDLE;
        end
        RMW_MERGE: begin
          lat_data   <= merged;
          resp_valid <= 1'b1;
          resp_data  <= '0;
          resp_rd    <= lat_rd;
          state      <= ST_WRITE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_lsu.sv
// Self-checking bench for rv32_lsu: BRAM model, a transaction-level
// reference model compared every cycle, and directed literal checks.
module tb_rv32_lsu;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_mode = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_store = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic [4:0]    req_rd = 5'd0;
  logic          resp_valid, resp_we, resp_misaligned, resp_illegal;
  logic [4:0]    resp_rd;
  logic [31:0]   resp_data;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [31:0]   mem_rdata, mem_wdata;
  logic          mem_wen;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] bram    [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  rv32_lsu #(.DMEM_AW(AW), .RESET_RESP_RD(5'd0)) dut (
    .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .resp_valid(resp_valid), .resp_we(resp_we),
    .resp_rd(resp_rd), .resp_data(resp_data),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM: registered read (read-first), write with no byte enables.
  initial begin
    for (int i = 0; i < (1 << AW); i++) bram[i] <= 32'd0;
    bram[5] <= 32'h8081_F2F3;
  end
  always @(posedge clk) begin
    if (mem_wen) bram[mem_waddr] <= mem_wdata;
    mem_rdata <= bram[mem_raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] word,
                                             input logic [1:0] lane);
    logic [31:0] sh;
    sh = word >> (8 * lane);
    case (f3)
      3'b000:  return 32'($signed(sh[7:0]));
      3'b100:  return 32'(sh[7:0]);
      3'b001:  return 32'($signed(sh[15:0]));
      3'b101:  return 32'(sh[15:0]);
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [2:0] f3, input logic [31:0] word,
                                              input logic [31:0] wd, input logic [1:0] lane);
    logic [31:0] mask;
    mask = (f3 == 3'b000) ? 32'h0000_00FF : 32'h0000_FFFF;
    return (word & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
  endfunction

  int          resp_cyc = -1, wr_cyc = -1, ready_from = 0;
  logic [31:0] exp_data, exp_wdata, last_data;
  logic [4:0]  exp_rd, last_rd;
  logic        exp_we, exp_mis, exp_ill;
  logic [AW-1:0] exp_waddr;

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'd0;
    ref_mem[5] = 32'h8081_F2F3;
    last_data = 32'd0;
    last_rd = 5'd0;
  end

  // Compare process: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("wen_in_reset", 32'(mem_wen), 32'd0);
      resp_cyc = -1; wr_cyc = -1; ready_from = 0;
      last_data = 32'd0; last_rd = 5'd0;
    end else begin
      check("resp_valid", 32'(resp_valid), 32'(resp_cyc == cyc));
      if (resp_cyc == cyc) begin
        check("resp_we", 32'(resp_we), 32'(exp_we));
        check("resp_rd", 32'(resp_rd), 32'(exp_rd));
        check("resp_data", resp_data, exp_data);
        check("resp_misaligned", 32'(resp_misaligned), 32'(exp_mis));
        check("resp_illegal", 32'(resp_illegal), 32'(exp_ill));
        last_data = exp_data; last_rd = exp_rd;
      end else begin
        check("resp_data_hold", resp_data, last_data);
        check("resp_rd_hold", 32'(resp_rd), 32'(last_rd));
      end
      check("mem_wen", 32'(mem_wen), 32'(wr_cyc == cyc));
      if (wr_cyc == cyc) begin
        check("mem_waddr", 32'(mem_waddr), 32'(exp_waddr));
        check("mem_wdata", mem_wdata, exp_wdata);
        ref_mem[exp_waddr] = exp_wdata;
      end
      check("req_ready", 32'(req_ready), 32'((cyc >= ready_from) && !prog_mode));
      if (req_valid && req_ready) begin
        logic [AW-1:0] wa;
        logic mis, ill;
        wa  = req_addr[AW+1:2];
        mis = (((req_funct3 == 3'b001) || (req_funct3 == 3'b101)) && req_addr[0]) ||
              ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
        ill = req_store ? (req_funct3 > 3'b010)
                        : ((req_funct3 == 3'b011) || (req_funct3 >= 3'b110));
        exp_rd = req_rd; exp_mis = mis; exp_ill = ill; exp_we = 1'b0; exp_data = 32'd0;
        exp_waddr = wa;
        if (mis || ill) begin
          resp_cyc = cyc + 1; ready_from = cyc + 1;
        end else if (!req_store) begin
          exp_we = 1'b1;
          exp_data = model_load(req_funct3, ref_mem[wa], req_addr[1:0]);
          resp_cyc = cyc + 2; ready_from = cyc + 2;
        end else if (req_funct3 == 3'b010) begin
          exp_wdata = req_wdata;
          resp_cyc = cyc + 1; wr_cyc = cyc + 1; ready_from = cyc + 2;
        end else begin
          exp_wdata = model_merge(req_funct3, ref_mem[wa], req_wdata, req_addr[1:0]);
          resp_cyc = cyc + 2; wr_cyc = cyc + 2; ready_from = cyc + 3;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Drive a request and hold it until accepted; returns at the start of T+1.
  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [4:0] rd);
    bit ok = 0;
    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL handshake_timeout: addr %h not accepted in 20 cycles", a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Wait for the response pulse; lat counts cycles after the handshake cycle.
  task automatic wait_resp(output int lat, output logic [31:0] d, output logic we,
                           output logic mis, output logic ill);
    lat = 0; d = 'x; we = 'x; mis = 'x; ill = 'x;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i; d = resp_data; we = resp_we; mis = resp_misaligned; ill = resp_illegal;
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: no resp_valid within 10 cycles");
    end
    @(posedge clk); #1;
  endtask

  int lat;
  logic [31:0] d;
  logic we, mis, ill;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rd", 32'(resp_rd), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Loads from word 5 = 0x8081_F2F3
    send(0, 3'b000, 32'h17, 0, 5'd1); wait_resp(lat, d, we, mis, ill);
    check("lb_lat", lat, 2); check("lb_data", d, 32'hFFFF_FF80); check("lb_we", 32'(we), 1);
    send(0, 3'b100, 32'h17, 0, 5'd2); wait_resp(lat, d, we, mis, ill);
    check("lbu_data", d, 32'h0000_0080);
    send(0, 3'b001, 32'h16, 0, 5'd3); wait_resp(lat, d, we, mis, ill);
    check("lh_data", d, 32'hFFFF_8081);
    send(0, 3'b101, 32'h14, 0, 5'd4); wait_resp(lat, d, we, mis, ill);
    check("lhu_data", d, 32'h0000_F2F3);
    send(0, 3'b010, 32'h4000_0014, 0, 5'd5); wait_resp(lat, d, we, mis, ill);
    check("lw_wrap_data", d, 32'h8081_F2F3);

    // SW then back-to-back LW of the same word
    send(1, 3'b010, 32'h20, 32'hDEAD_BEEF, 5'd6); wait_resp(lat, d, we, mis, ill);
    check("sw_lat", lat, 1); check("sw_we", 32'(we), 0);
    send(0, 3'b010, 32'h20, 0, 5'd7); wait_resp(lat, d, we, mis, ill);
    check("lw_after_sw", d, 32'hDEAD_BEEF);

    // Sub-word read-modify-write stores into word 8
    send(1, 3'b010, 32'h20, 32'h1122_3344, 5'd0); wait_resp(lat, d, we, mis, ill);
    send(1, 3'b000, 32'h21, 32'hFFFF_FFAB, 5'd0); wait_resp(lat, d, we, mis, ill);
    check("sb_lat", lat, 2); check("sb_word", bram[8], 32'h1122_AB44);
    send(1, 3'b001, 32'h22, 32'h1234_5566, 5'd0); wait_resp(lat, d, we, mis, ill);
    check("sh_word", bram[8], 32'h5566_AB44);

    // Faults
    send(0, 3'b010, 32'h22, 0, 5'd8); wait_resp(lat, d, we, mis, ill);
    check("lw_mis_lat", lat, 1); check("lw_mis_flag", 32'(mis), 1);
    check("lw_mis_we", 32'(we), 0); check("lw_mis_data", d, 0);
    send(1, 3'b001, 32'h23, 32'hFFFF, 5'd0); wait_resp(lat, d, we, mis, ill);
    check("sh_mis_flag", 32'(mis), 1); check("sh_mis_mem", bram[8], 32'h5566_AB44);
    send(1, 3'b100, 32'h20, 32'hFFFF, 5'd0); wait_resp(lat, d, we, mis, ill);
    check("st_ill_flag", 32'(ill), 1); check("st_ill_mis", 32'(mis), 0);
    send(0, 3'b011, 32'h20, 0, 5'd9); wait_resp(lat, d, we, mis, ill);
    check("ld_ill_flag", 32'(ill), 1);

    // Reset in the middle of an SB aborts it
    send(1, 3'b000, 32'h21, 32'h77, 5'd0);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_wen", 32'(mem_wen), 0);
      check("abort_no_resp", 32'(resp_valid), 0);
    end
    check("abort_ready", 32'(req_ready), 1);
    check("abort_mem", bram[8], 32'h5566_AB44);
    @(posedge clk); #1;

    // prog_mode blocks acceptance; dropping it accepts in that same cycle
    prog_mode = 1'b1;
    req_store = 0; req_funct3 = 3'b100; req_addr = 32'h14; req_rd = 5'd10; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("prog_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1 prog_mode = 1'b0;
    @(negedge clk);
    check("prog_drop_ready", 32'(req_ready), 1);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_resp(lat, d, we, mis, ill);
    check("prog_lbu_lat", lat, 2); check("prog_lbu_data", d, 32'h0000_00F3);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
